dwt_lifting_53_line: RTL and testbench

Single-channel 1-D LeGall 5/3 lifting wavelet engine for one line of SIZE 8-bit samples. It produces valid-region high-pass (detail) and low-pass (approximation) coefficients, with no boundary extension. The 2-D DWT top level instantiates one engine for the row pass and one per band for the column pass. Each line is framed by a one-cycle DWT_rst pulse.

---
 rtl/dwt_lifting_53_line.sv | 104 ++++++++++
 tb/tb_dwt_lifting_53_line.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dwt_lifting_53_line.sv
// rtl/dwt_lifting_53_line.sv - one-line LeGall 5/3 lifting engine, valid-region detail/approximation outputs
module dwt_lifting_53_line #(
    parameter int SIZE = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] data_in,
    input  logic       DWT_rst,
    output logic       high_en,
    output logic [7:0] high_o,
    output logic       low_en,
    output logic [7:0] low_o
);

    localparam int KW = $clog2(SIZE) + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [KW-1:0] k;
    logic          last_sample;
    logic          capture;
    logic          d_strobe;
    logic          s_strobe;

    // Two most recent samples: x_m1 = x[k-1], x_m2 = x[k-2] at the capture of x[k]
    logic [7:0]        x_m1, x_m2;
    logic signed [10:0] d_prev;

    logic signed [10:0] x_cur_s, x_m1_s, x_m2_s;
    logic signed [10:0] sum_even, d_cur, sum_d;
    logic [7:0]         s_low;

    assign last_sample = (k == KW'(SIZE - 1));

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    // Next state: line start wins over everything, line ends after the last sample
    always_comb begin
        state_next = state;
        if (DWT_rst)                              state_next = ACTIVE;
        else if (state == ACTIVE && last_sample)  state_next = IDLE;
    end

    // Control outputs: capture qualifier and coefficient strobes on even sample indices
    always_comb begin
        capture  = (state == ACTIVE) && !DWT_rst;
        d_strobe = capture && !k[0] && (k >= KW'(2));
        s_strobe = d_strobe && (k >= KW'(4));
    end

    // Lifting arithmetic: predict (detail) then update (approximation) using the fresh detail
    always_comb begin
        x_cur_s  = {3'b000, data_in};
        x_m1_s   = {3'b000, x_m1};
        x_m2_s   = {3'b000, x_m2};
        sum_even = x_m2_s + x_cur_s;
        d_cur    = x_m1_s - (sum_even >>> 1);
        sum_d    = d_prev + d_cur + 11'sd2;
        s_low    = 8'(x_m2_s + (sum_d >>> 2));
    end

    // Sample history, sample counter and registered coefficient outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            k       <= '0;
            x_m1    <= '0;
            x_m2    <= '0;
            d_prev  <= '0;
            high_en <= 1'b0;
            high_o  <= '0;
            low_en  <= 1'b0;
            low_o   <= '0;
        end else begin
            high_en <= 1'b0;
            low_en  <= 1'b0;
            if (DWT_rst) begin
                k      <= '0;
                x_m1   <= '0;
                x_m2   <= '0;
                d_prev <= '0;
            end else if (capture) begin
                k    <= k + KW'(1);
                x_m2 <= x_m1;
                x_m1 <= data_in;
                if (d_strobe) begin
                    high_o  <= d_cur[7:0];
                    high_en <= 1'b1;
                    d_prev  <= d_cur;
                end
                if (s_strobe) begin
                    low_o  <= s_low;
                    low_en <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dwt_lifting_53_line.sv
// tb/tb_dwt_lifting_53_line.sv - self-checking bench for dwt_lifting_53_line against an array-based 5/3 model
module tb_dwt_lifting_53_line;

    localparam int SIZE = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       dwt_rst;
    logic       high_en;
    logic [7:0] high_o;
    logic       low_en;
    logic [7:0] low_o;

    int tests = 0;
    int fails = 0;

    int xs   [0:63];
    int dref [0:31];
    int sref [0:31];

    dwt_lifting_53_line #(.SIZE(SIZE)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .data_in (data_in),
        .DWT_rst (dwt_rst),
        .high_en (high_en),
        .high_o  (high_o),
        .low_en  (low_en),
        .low_o   (low_o)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        for (int n = 0; n <= SIZE/2 - 2; n++)
            dref[n] = xs[2*n+1] - floor_div(xs[2*n] + xs[2*n+2], 2);
        for (int m = 0; m <= SIZE/2 - 3; m++)
            sref[m] = xs[2*m+2] + floor_div(dref[m] + dref[m+1] + 2, 4);
    endtask

    // One DWT_rst cycle followed by nsamp sample cycles; every cycle's strobes checked
    task automatic drive_line(input string name, input int nsamp);
        int hcnt, lcnt;
        bit exp_h, exp_l;
        hcnt = 0;
        lcnt = 0;
        build_model();
        @(negedge clk);
        dwt_rst = 1'b1;
        data_in = 8'($urandom);
        @(posedge clk); #1;
        check({name, "_start_high_en"}, {7'd0, high_en}, 8'd0);
        check({name, "_start_low_en"},  {7'd0, low_en},  8'd0);
        for (int j = 0; j < nsamp; j++) begin
            @(negedge clk);
            dwt_rst = 1'b0;
            data_in = (j < SIZE) ? 8'(xs[j]) : 8'($urandom);
            @(posedge clk); #1;
            exp_h = (j < SIZE) && (j % 2 == 0) && (j >= 2);
            exp_l = exp_h && (j >= 4);
            check($sformatf("%s_high_en_j%0d", name, j), {7'd0, high_en}, {7'd0, exp_h});
            check($sformatf("%s_low_en_j%0d",  name, j), {7'd0, low_en},  {7'd0, exp_l});
            if (exp_h) check($sformatf("%s_d%0d", name, (j-2)/2), high_o, 8'(dref[(j-2)/2]));
            if (exp_l) check($sformatf("%s_s%0d", name, (j-4)/2), low_o,  8'(sref[(j-4)/2]));
            if (high_en) hcnt++;
            if (low_en)  lcnt++;
        end
        if (nsamp >= SIZE) begin
            check({name, "_high_count"}, 8'(hcnt), 8'(SIZE/2 - 1));
            check({name, "_low_count"},  8'(lcnt), 8'(SIZE/2 - 2));
        end
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            dwt_rst = 1'b0;
            data_in = 8'($urandom);
            @(posedge clk); #1;
            check($sformatf("%s_high_en_%0d", name, j), {7'd0, high_en}, 8'd0);
            check($sformatf("%s_low_en_%0d",  name, j), {7'd0, low_en},  8'd0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        dwt_rst = 1'b0;
        data_in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_high_en", {7'd0, high_en}, 8'd0);
        check("reset_low_en",  {7'd0, low_en},  8'd0);
        check("reset_high_o",  high_o, 8'd0);
        check("reset_low_o",   low_o,  8'd0);
        @(negedge clk);
        rst = 1'b0;

        idle_cycles("pre_line", 20);

        for (int j = 0; j < 64; j++) xs[j] = 100;
        drive_line("const100", SIZE);

        for (int j = 0; j < 64; j++) xs[j] = j;
        drive_line("ramp", SIZE);

        for (int j = 0; j < 64; j++) xs[j] = (j % 2 == 0) ? 0 : 10;
        drive_line("alt_0_10", SIZE);

        for (int j = 0; j < 64; j++) xs[j] = (j % 2 == 0) ? 10 : 0;
        drive_line("alt_10_0", SIZE + 4);

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 64; j++) xs[j] = $urandom_range(0, 255);
            drive_line($sformatf("rand%0d", r), SIZE);
        end

        for (int j = 0; j < 64; j++) xs[j] = $urandom_range(0, 255);
        drive_line("abort_part", 7);
        for (int j = 0; j < 64; j++) xs[j] = 50;
        drive_line("after_abort", SIZE + 2);

        for (int j = 0; j < 64; j++) xs[j] = $urandom_range(1, 255);
        drive_line("pre_sysrst", 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("sysrst_high_en", {7'd0, high_en}, 8'd0);
        check("sysrst_low_en",  {7'd0, low_en},  8'd0);
        check("sysrst_high_o",  high_o, 8'd0);
        check("sysrst_low_o",   low_o,  8'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles("post_sysrst", 20);

        for (int j = 0; j < 64; j++) xs[j] = $urandom_range(0, 255);
        drive_line("recover", SIZE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
